// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one unified instruction/data memory port between the
//                multicycle core and a debug/loader port. Each access runs
//                IDLE -> ACCESS -> WAIT (WAIT_CYCLES cycles) -> DONE, with a
//                single mem_en strobe in ACCESS and a one-cycle ack plus read
//                data returned to the winning requester in DONE.
//  Config      : define MEM_ARB_RR_EN for round-robin arbitration on a tie;
//                otherwise fixed priority with the core first.
//  Ports       : clk, reset (async, active-high)
//                core_* / dbg_*  requester ports (req/we/addr/wdata/wstrb in,
//                                ack/rdata out)
//                mem_*           memory macro port (en/we/addr/wdata/wstrb
//                                out, rdata in)
//                busy            not IDLE
//                owner           0 = core, 1 = debug (current/last access)
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                reset,
  // core requester
  input  logic                core_req,
  input  logic                core_we,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic [DATA_W-1:0]   core_wdata,
  input  logic [DATA_W/8-1:0] core_wstrb,
  output logic                core_ack,
  output logic [DATA_W-1:0]   core_rdata,
  // debug/loader requester
  input  logic                dbg_req,
  input  logic                dbg_we,
  input  logic [ADDR_W-1:0]   dbg_addr,
  input  logic [DATA_W-1:0]   dbg_wdata,
  input  logic [DATA_W/8-1:0] dbg_wstrb,
  output logic                dbg_ack,
  output logic [DATA_W-1:0]   dbg_rdata,
  // memory macro
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  // status
  output logic                busy,
  output logic                owner
);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_access = 2'd1;
  localparam logic [1:0] c_st_wait   = 2'd2;
  localparam logic [1:0] c_st_done   = 2'd3;

  // Counter preload; clamped so a zero-wait build never forms WAIT_CYCLES-1 < 0.
  localparam int         c_wait_m1   = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [3:0] c_wait_load = 4'(c_wait_m1);
  localparam logic       c_has_wait  = (WAIT_CYCLES > 0);

  logic [1:0]          r_state;
  logic [1:0]          w_next_state;
  logic [3:0]          r_wait_cnt;
  logic                r_owner;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W/8-1:0] r_mem_wstrb;
  logic                w_any_req;
  logic                w_grant_dbg;

  assign w_any_req = core_req | dbg_req;

`ifdef MEM_ARB_RR_EN
  // Last-served port; starts at debug so the core takes the first tie.
  logic r_last_dbg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_dbg <= 1'b1;
    end else if (r_state == c_st_done) begin
      r_last_dbg <= r_owner;
    end
  end

  // A lone debug request always wins; on a tie debug wins only if the core
  // was served last.
  assign w_grant_dbg = dbg_req & (~core_req | ~r_last_dbg);
`else
  assign w_grant_dbg = dbg_req & ~core_req;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle:   if (w_any_req) w_next_state = c_st_access;
      c_st_access: w_next_state = c_has_wait ? c_st_wait : c_st_done;
      c_st_wait:   if (r_wait_cnt == 4'd0) w_next_state = c_st_done;
      c_st_done:   w_next_state = c_st_idle;
      default:     w_next_state = c_st_idle;
    endcase
  end

  // --------------------------------------------------------------------------
  // Access latches and wait counter. The mem_* fields are captured once in
  // IDLE and then held until the next grant.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner     <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_wait_cnt  <= 4'd0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_any_req) begin
            r_owner     <= w_grant_dbg;
            r_mem_we    <= w_grant_dbg ? dbg_we    : core_we;
            r_mem_addr  <= w_grant_dbg ? dbg_addr  : core_addr;
            r_mem_wdata <= w_grant_dbg ? dbg_wdata : core_wdata;
            r_mem_wstrb <= w_grant_dbg ? dbg_wstrb : core_wstrb;
          end
        end
        c_st_access: r_wait_cnt <= c_wait_load;
        c_st_wait:   if (r_wait_cnt != 4'd0) r_wait_cnt <= r_wait_cnt - 4'd1;
        default:     ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Strobes decode from state so an asynchronous reset drops them
  // immediately; read data passes straight through to the owner in DONE.
  // --------------------------------------------------------------------------
  always_comb begin
    mem_en     = 1'b0;
    busy       = (r_state != c_st_idle);
    core_ack   = 1'b0;
    dbg_ack    = 1'b0;
    core_rdata = '0;
    dbg_rdata  = '0;
    case (r_state)
      c_st_access: mem_en = 1'b1;
      c_st_done: begin
        if (r_owner) begin
          dbg_ack   = 1'b1;
          dbg_rdata = mem_rdata;
        end else begin
          core_ack   = 1'b1;
          core_rdata = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;
  assign owner     = r_owner;

endmodule
`default_nettype wire
